mem_responder: RTL

//   Memory-side responder for the picorv32-style valid/ready bus driven by the riscv core.

---
 rtl/mem_responder.sv | 88 ++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory responder with wait states, byte-strobed stores and sticky fault flag
// Ports:
//   clk, reset (sync, active-low)
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb : request from core (wstrb==0 means read)
//   mem_ready : one-cycle response strobe; mem_rdata : read data valid with mem_ready
//   fault     : sticky flag set by an out-of-range access or an instruction fetch with strobes
module mem_responder #(
  parameter int          WORDS       = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr, wdata, off, cnt, cnt_n, rdata_n;
  logic [3:0] wstrb;
  logic instr, in_range, illegal, ready_n, fault_n;
  logic [IW-1:0] idx;
  logic [31:0] ram [WORDS];
  assign off = addr - BASE_ADDR;
  assign idx = off[IW+1:2];
  assign in_range = (addr >= BASE_ADDR) && ((off >> 2) < 32'(WORDS));
  assign illegal = !in_range || (instr && wstrb != 4'b0000);
  // The response is produced when the wait count expires, so mem_ready and the
  // read data are registered into the RESP cycle itself; RESP then just returns
  // to IDLE while the write commits on its closing edge.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ready_n = 1'b0;
    rdata_n = mem_rdata;
    fault_n = fault;
    case (state)
      IDLE: begin
        state_n = mem_valid ? WAIT : IDLE;
        cnt_n = mem_valid ? 32'(WAIT_CYCLES) : cnt;
      end
      WAIT: begin
        state_n = cnt == 32'd0 ? RESP : WAIT;
        cnt_n = cnt == 32'd0 ? cnt : cnt - 32'd1;
        ready_n = cnt == 32'd0;
        rdata_n = cnt != 32'd0 ? mem_rdata : illegal ? 32'd0 : ram[idx];
        fault_n = fault | (cnt == 32'd0 && illegal);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 32'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_ready <= ready_n;
      mem_rdata <= rdata_n;
      fault <= fault_n;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_valid) begin
      addr <= mem_addr;
      wdata <= mem_wdata;
      wstrb <= mem_wstrb;
      instr <= mem_instr;
    end
  end
  // Gated by reset so an abandoned request never commits.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && !illegal)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule
